mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the fetcher's byte-serial RAM port.
- Serves one byte per cycle from internal RAM with one-cycle read latency, and accepts byte writes.
- Decodes the IO window (addr[17:16]==2'b11) into a TX FIFO toward the host UART, an RX FIFO from the host, a status register and a halt register.
- Drives the io-full flag that the fetcher samples before issuing an IO store.

Parameters:
- RamAddrBits, 17, RAM byte-address width; RAM depth is 2^RamAddrBits.
- TxDepthLog, 3, log2 of TX FIFO depth (8 entries).
- RxDepthLog, 3, log2 of RX FIFO depth (8 entries).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; when 0, no access takes effect.
- addr_from_fc  input  32  byte address.
- is_store_from_fc  input  1  1 = write data_from_fc at addr_from_fc this cycle.
- data_from_fc  input  8  write byte.
- data_to_fc  output  8  read byte, registered, valid the cycle after the address.
- is_full_to_fc  output  1  TX FIFO has fewer than 2 free slots.
- tx_valid  output  1  TX FIFO head valid.
- tx_data  output  8  TX FIFO head byte.
- tx_ready  input  1  host consumes head when tx_valid&&tx_ready.
- rx_valid  input  1  host offers a byte.
- rx_data  input  8  offered byte.
- rx_ready  output  1  RX FIFO not full.
- halt  output  1  sticky; set by a write to 0x30004.
- overflow_err  output  1  sticky; set when a TX write is dropped.

Behaviour:
- Reset (rst==0, asynchronous):
  - all outputs 0 except rx_ready=1;
  - FIFO pointers and counts 0;
  - RAM contents are not reset.
- Decode: io = (addr_from_fc[17:16]==2'b11). Otherwise RAM index = addr_from_fc[RamAddrBits-1:0].
- RAM read (rdy=1, store=0, !io): data_to_fc <= ram[idx] at the next edge. Address 0 is an ordinary RAM read with no side effect; the fetcher's idle address is 0.
- RAM write (rdy=1, store=1, !io): ram[idx] <= data_from_fc. data_to_fc holds its value.
- IO read, addr[2:0]==0 (0x30000):
  - RX non-empty: data_to_fc <= RX head and pop RX.
  - RX empty: data_to_fc <= 0, no pop.
  - One pop per cycle the address is presented. The fetcher reads each address once.
- IO read, addr[2:0]==4 (0x30004): data_to_fc <= {6'b0, rx_nonempty, is_full_to_fc}. No side effect.
- IO write 0x30000:
  - TX not full: push data_from_fc.
  - TX full: drop the byte and set overflow_err.
- IO write 0x30004: halt <= 1.
- Other IO offsets: reads return 0; writes are ignored.
- rdy=0: no RAM or IO side effect and data_to_fc holds. Host-side FIFO handshakes (tx pop, rx push) continue.
- is_full_to_fc is registered from next-state TX count: 1 when count > 2^TxDepthLog - 2. The two-slot margin covers the fetcher's one-cycle gap between sampling full and writing.
- TX pop: on tx_valid && tx_ready; tx_data = head, combinational from the FIFO.
- RX push: on rx_valid && rx_ready. rx_ready = !rx_full, combinational.
- Simultaneous push and pop on the same FIFO in one cycle:
  - both occur and the count is unchanged;
  - a push into a full FIFO that pops this cycle is still rejected (full is evaluated before the pop).
- Pointers are TxDepthLog/RxDepthLog bits and wrap naturally. Counts are one bit wider.
- Reset asserted mid-stream: FIFOs empty immediately and in-flight bytes are lost. halt and overflow_err clear.

Test Plan:
- RAM write then read: write 0xA5 @0x00123, next cycle read 0x00123 -> data_to_fc==0xA5 one cycle later. Idle reads of addr 0 cause no state change.
- Burst read: addresses 0x10..0x13 holding 11,22,33,44 in consecutive cycles -> data_to_fc is 11,22,33,44, each lagging by exactly one cycle.
- TX full margin, tx_ready=0:
  - after 6 writes to 0x30000, is_full_to_fc==0;
  - after the 7th, it goes to 1 at the next edge;
  - the 8th write is accepted; the 9th is dropped and overflow_err==1;
  - with tx_ready=1 afterwards, 8 bytes drain in order.
- RX path: host pushes 0x41, 0x42. Read 0x30004 -> 0x02. Read 0x30000 twice -> 0x41, 0x42. A third read -> 0x00, and the status read -> 0x00.
- rdy=0 for 3 cycles with store=1 @0x30000 and @0x00050: no TX push, RAM unchanged, data_to_fc constant, host tx drain continues.
- Write 0x30004 -> halt==1 and stays 1. Assert rst=0 asynchronously between edges -> halt, overflow_err, tx_valid drop to 0 immediately; rx_ready==1.

Source files
------------

// File: rtl/mem_io_responder.sv
// Memory-side responder for the fetcher's byte-serial port: internal RAM plus an
// IO window (addr[17:16]==2'b11) with TX/RX FIFOs to the host, status and halt.
module mem_io_responder #(
  parameter int RamAddrBits = 17,
  parameter int TxDepthLog  = 3,
  parameter int RxDepthLog  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr_from_fc,
  input  logic        is_store_from_fc,
  input  logic [7:0]  data_from_fc,
  output logic [7:0]  data_to_fc,
  output logic        is_full_to_fc,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt,
  output logic        overflow_err
);
  localparam int TxDepth = 1 << TxDepthLog;
  localparam int RxDepth = 1 << RxDepthLog;

  logic [7:0] ram [2**RamAddrBits];
  logic [7:0] tx_mem [TxDepth];
  logic [7:0] rx_mem [RxDepth];

  logic [TxDepthLog-1:0] tx_wr, tx_rd;
  logic [TxDepthLog:0]   tx_cnt, tx_cnt_nxt;
  logic [RxDepthLog-1:0] rx_wr, rx_rd;
  logic [RxDepthLog:0]   rx_cnt;

  logic                   io, rd_acc, wr_acc;
  logic [2:0]             off;
  logic [RamAddrBits-1:0] ram_idx;
  logic                   tx_req, tx_push, tx_pop, tx_full;
  logic                   rx_push, rx_pop, rx_full, rx_nonempty;
  logic                   unused_addr;

  assign io          = (addr_from_fc[17:16] == 2'b11);
  assign off         = addr_from_fc[2:0];
  assign ram_idx     = addr_from_fc[RamAddrBits-1:0];
  assign unused_addr = ^addr_from_fc[31:18];
  assign rd_acc      = rdy && !is_store_from_fc;
  assign wr_acc      = rdy && is_store_from_fc;

  // Full is judged on the pre-pop count, so a push into a full FIFO is
  // rejected even if the host pops in the same cycle.
  assign tx_full    = tx_cnt[TxDepthLog];
  assign tx_valid   = (tx_cnt != '0);
  assign tx_data    = tx_mem[tx_rd];
  assign tx_req     = wr_acc && io && (off == 3'd0);
  assign tx_push    = tx_req && !tx_full;
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_cnt_nxt = tx_cnt + (TxDepthLog+1)'(tx_push) - (TxDepthLog+1)'(tx_pop);

  assign rx_full     = rx_cnt[RxDepthLog];
  assign rx_nonempty = (rx_cnt != '0);
  assign rx_ready    = !rx_full;
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = rd_acc && io && (off == 3'd0) && rx_nonempty;

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !io) ram[ram_idx] <= data_from_fc;
    if (tx_push)       tx_mem[tx_wr] <= data_from_fc;
    if (rx_push)       rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      tx_cnt        <= '0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      rx_cnt        <= '0;
      data_to_fc    <= '0;
      is_full_to_fc <= 1'b0;
      halt          <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TxDepthLog'(1);
      if (tx_pop)  tx_rd <= tx_rd + TxDepthLog'(1);
      tx_cnt        <= tx_cnt_nxt;
      // Two-slot margin: the fetcher writes one cycle after sampling this.
      is_full_to_fc <= (tx_cnt_nxt > (TxDepthLog+1)'(TxDepth - 2));

      if (rx_push) rx_wr <= rx_wr + RxDepthLog'(1);
      if (rx_pop)  rx_rd <= rx_rd + RxDepthLog'(1);
      rx_cnt <= rx_cnt + (RxDepthLog+1)'(rx_push) - (RxDepthLog+1)'(rx_pop);

      if (tx_req && tx_full)                  overflow_err <= 1'b1;
      if (wr_acc && io && (off == 3'd4))      halt         <= 1'b1;

      if (rd_acc) begin
        if (!io) data_to_fc <= ram[ram_idx];
        else begin
          case (off)
            3'd0:    data_to_fc <= rx_nonempty ? rx_mem[rx_rd] : 8'h00;
            3'd4:    data_to_fc <= {6'b0, rx_nonempty, is_full_to_fc};
            default: data_to_fc <= 8'h00;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read results and TX bytes are queued
// when driven and compared when the DUT delivers them.
module tb_mem_io_responder;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] addr;
  logic        st;
  logic [7:0]  wd;
  logic [7:0]  data_to_fc;
  logic        is_full_to_fc, tx_valid, tx_ready, rx_valid, rx_ready, halt, overflow_err;
  logic [7:0]  tx_data, rx_data;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .addr_from_fc(addr), .is_store_from_fc(st),
    .data_from_fc(wd), .data_to_fc(data_to_fc), .is_full_to_fc(is_full_to_fc),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .halt(halt), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  bit         rd_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Host TX monitor runs before the edge; read results are checked after it.
  task automatic step();
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_extra", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                  chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end
    @(posedge clk); #1;
    if (rd_pend) begin
      rd_pend = 1'b0;
      chk("rd_data", {24'h0, data_to_fc}, {24'h0, rd_q.pop_front()});
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rdy = 1'b1; st = 1'b1; addr = a; wd = d;
    step();
    st = 1'b0; addr = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    rdy = 1'b1; st = 1'b0; addr = a;
    rd_q.push_back(e); rd_pend = 1'b1;
    step();
    addr = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rdy = 1'b0; addr = '0; st = 1'b0; wd = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1;
    chk("rst_data", {24'h0, data_to_fc}, 32'h0);
    chk("rst_full", {31'h0, is_full_to_fc}, 32'h0);
    chk("rst_txv", {31'h0, tx_valid}, 32'h0);
    chk("rst_rxr", {31'h0, rx_ready}, 32'h1);
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_ovf", {31'h0, overflow_err}, 32'h0);
    #10 rst = 1'b1;
    idle(2);

    // RAM write then read, idle reads of 0 leave state alone
    wr(32'h0_0123, 8'hA5);
    rd(32'h0_0123, 8'hA5);
    idle(3);
    rd(32'h0_0123, 8'hA5);
    chk("idle_txv", {31'h0, tx_valid}, 32'h0);
    chk("idle_halt", {31'h0, halt}, 32'h0);

    // Burst read with one-cycle lag
    wr(32'h10, 8'h11); wr(32'h11, 8'h22); wr(32'h12, 8'h33); wr(32'h13, 8'h44);
    rd(32'h10, 8'h11); rd(32'h11, 8'h22); rd(32'h12, 8'h33); rd(32'h13, 8'h44);

    // TX full margin and overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(32'h3_0000, 8'h60 + 8'(i));
      tx_q.push_back(8'h60 + 8'(i));
    end
    chk("full_at6", {31'h0, is_full_to_fc}, 32'h0);
    wr(32'h3_0000, 8'h66); tx_q.push_back(8'h66);
    chk("full_at7", {31'h0, is_full_to_fc}, 32'h1);
    wr(32'h3_0000, 8'h67); tx_q.push_back(8'h67);
    chk("ovf_at8", {31'h0, overflow_err}, 32'h0);
    wr(32'h3_0000, 8'hDD);
    chk("ovf_at9", {31'h0, overflow_err}, 32'h1);
    // Push into a full FIFO while the host pops: still rejected
    tx_ready = 1'b1;
    wr(32'h3_0000, 8'hEE);
    idle(10);
    chk("tx_left", tx_q.size(), 32'h0);
    chk("tx_empty", {31'h0, tx_valid}, 32'h0);
    chk("full_drained", {31'h0, is_full_to_fc}, 32'h0);

    // RX path
    rx_valid = 1'b1; rx_data = 8'h41; step();
    rx_data = 8'h42; step();
    rx_valid = 1'b0;
    rd(32'h3_0004, 8'h02);
    rd(32'h3_0000, 8'h41);
    rd(32'h3_0000, 8'h42);
    rd(32'h3_0000, 8'h00);
    rd(32'h3_0004, 8'h00);
    rd(32'h3_0002, 8'h00);

    // rdy=0: no side effects, host drain continues
    tx_ready = 1'b0;
    wr(32'h3_0000, 8'h91); tx_q.push_back(8'h91);
    wr(32'h3_0000, 8'h92); tx_q.push_back(8'h92);
    wr(32'h0_0050, 8'h77);
    rd(32'h0_0050, 8'h77);
    rdy = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st = 1'b1; wd = 8'hEE;
      addr = (i % 2 == 1) ? 32'h0_0050 : 32'h3_0000;
      step();
      chk("hold_data", {24'h0, data_to_fc}, 32'h77);
    end
    st = 1'b0; addr = '0; rdy = 1'b1;
    chk("rdy0_drained", tx_q.size(), 32'h0);
    chk("rdy0_nopush", {31'h0, tx_valid}, 32'h0);
    rd(32'h0_0050, 8'h77);

    // Halt, then asynchronous reset between edges
    tx_ready = 1'b0;
    wr(32'h3_0004, 8'h00);
    chk("halt_set", {31'h0, halt}, 32'h1);
    idle(3);
    chk("halt_sticky", {31'h0, halt}, 32'h1);
    wr(32'h3_0000, 8'h33);
    chk("pre_rst_txv", {31'h0, tx_valid}, 32'h1);
    #3 rst = 1'b0;
    #1;
    chk("arst_halt", {31'h0, halt}, 32'h0);
    chk("arst_ovf", {31'h0, overflow_err}, 32'h0);
    chk("arst_txv", {31'h0, tx_valid}, 32'h0);
    chk("arst_rxr", {31'h0, rx_ready}, 32'h1);
    #10 rst = 1'b1;
    idle(1);
    rd(32'h0_0123, 8'hA5);
    rd(32'h3_0004, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
